bpu_update_ctrl: RTL and testbench
==================================

Name: bpu_update_ctrl

Overview:
- Sequences predictor-table updates for entries committed out of the fetch target queue.
- Captures one update request, does a read-modify-write on the shared FTB table port, then signals completion so the queue can pop the entry.
- Table lookups from the predict pipeline always win the port; updates retry until granted.
- Sits between the queue's commit/update interface and the FTB table array.

Parameters:
- IDX_W, 9, FTB set-index width.
- TAG_W, 20, FTB tag width.
- RD_LAT, 1, cycles from read grant to `i_tbl_rd_vld` (1..4).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, active-low
- `i_bpu_commit`  in  1  update request; held until `o_update_finished`
- `i_updateInfo`  in  BPupdateInfo_t  `startAddr`, `fallthruAddr`, `targetAddr`, `branch_type`, `taken`, `mispred`, `hit_on_ubtb`, `hit_on_ftb`
- `o_update_finished`  out  1  one-cycle completion pulse
- `o_tbl_rd_req`  out  1  table read request
- `o_tbl_rd_idx`  out  IDX_W  read set index
- `o_tbl_rd_tag`  out  TAG_W  compare tag
- `i_tbl_rd_gnt`  in  1  read port granted this cycle
- `i_tbl_rd_vld`  in  1  read result valid
- `i_tbl_rd_hit`  in  1  tag matched
- `i_tbl_rd_ctr`  in  2  stored 2-bit direction counter
- `o_tbl_wr_req`  out  1  table write request
- `o_tbl_wr_idx`  out  IDX_W  write set index
- `o_tbl_wr_tag`  out  TAG_W  write tag
- `o_tbl_wr_ctr`  out  2  new counter
- `o_tbl_wr_target`  out  64  branch target
- `o_tbl_wr_fallthru`  out  64  fallthrough address
- `o_tbl_wr_btype`  out  BranchType::_  branch type
- `i_tbl_wr_gnt`  in  1  write port granted this cycle
- `o_upd_cnt`  out  32  completed updates
- `o_alloc_cnt`  out  32  miss allocations
- `o_skip_cnt`  out  32  writes skipped

Behaviour:
- Reset: one clock `clk`; asynchronous, active-low reset `rst`.
  - State goes to IDLE.
  - All outputs and counters are 0.
  - Latched request is cleared.
- Address slicing: idx = `startAddr[IDX_W:1]`; tag = `startAddr[IDX_W+TAG_W:IDX_W+1]`.
- IDLE:
  - If `i_bpu_commit` is high, latch `i_updateInfo` and go to RD_REQ.
  - `i_updateInfo` is ignored after latching.
- RD_REQ:
  - `o_tbl_rd_req`=1 with latched idx/tag.
  - If `i_tbl_rd_gnt`, load the latency counter with RD_LAT and go to RD_WAIT; otherwise stay.
  - There is no timeout.
- RD_WAIT:
  - Counter decrements each cycle.
  - Result is captured in the cycle `i_tbl_rd_vld`=1.
  - Assert that `i_tbl_rd_vld` arrives exactly RD_LAT cycles after the grant.
  - Then compute the write decision:
    - Hit: new ctr = taken ? sat_inc(ctr, 3) : sat_dec(ctr, 0).
      - Write if new ctr != old ctr OR `mispred`; otherwise skip.
    - Miss and taken: allocate with ctr=2'b10.
    - Miss and not taken: skip.
  - Write -> WR_REQ; skip -> DONE and increment `o_skip_cnt`.
- WR_REQ:
  - `o_tbl_wr_req`=1 with latched idx/tag, new ctr, target, fallthru, branch type.
  - On `i_tbl_wr_gnt`, go to DONE; increment `o_alloc_cnt` if the write was a miss allocation.
- DONE:
  - `o_update_finished`=1 for exactly this cycle; `o_upd_cnt`++; return to IDLE.
  - The queue pops in this cycle; the next request is sampled no earlier than the following cycle.
- Port exclusivity: `o_tbl_rd_req` and `o_tbl_wr_req` are never both 1.
  - Both are 0 outside RD_REQ and WR_REQ respectively.
- Request drop: if `i_bpu_commit` drops mid-sequence, the sequence still completes with the latched data.
  - No abort path; squashes do not affect committed updates.
- Counters wrap at 2^32.
- Reset mid-sequence: return to IDLE immediately.
  - Any pending read or write request is withdrawn asynchronously.
  - No finished pulse is issued.
- Combinational paths: none from `i_bpu_commit` to any output.
  - `o_update_finished` is a decode of registered state.

Test Plan:
1. Hit, taken, stored ctr=1, `startAddr`=0x8000_1000, RD_LAT=1, both grants immediate:
   - read idx 0x000; write ctr=2.
   - `o_update_finished` exactly 5 cycles after the commit is sampled.
   - `o_upd_cnt`=1.
2. Hit, taken, ctr=3, `mispred`=0:
   - no write request.
   - finished pulse follows the read result.
   - `o_skip_cnt`=1.
3. Miss, taken, `targetAddr`=0x8000_2000:
   - write ctr=2, target 0x8000_2000.
   - `o_alloc_cnt`=1.
4. Miss, not taken:
   - no write; skip path taken.
   - single finished pulse.
5. `i_tbl_rd_gnt` held low 7 cycles, then `i_tbl_wr_gnt` low 3 cycles:
   - `o_tbl_rd_req` held 8 cycles, then `o_tbl_wr_req` held 4 cycles.
   - Never both high.
   - Finished pulse is 1 cycle wide.
6. `rst` asserted during RD_WAIT:
   - all outputs 0 immediately.
   - after release, a new commit restarts from RD_REQ with counters at 0.

Source files
------------

// File: rtl/bpu_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bpu_update_ctrl (and bpu_update_pkg)
// Brief    : Sequences FTB read-modify-write updates for entries committed out
//            of the fetch target queue. Lookups own the table port; updates
//            keep requesting until granted, then pulse completion.
// Revision : 1.0 - initial release
// ============================================================================

package bpu_update_pkg;

  typedef logic [2:0] branch_type_t;

  typedef struct packed {
    logic [63:0]  startAddr;
    logic [63:0]  fallthruAddr;
    logic [63:0]  targetAddr;
    branch_type_t branch_type;
    logic         taken;
    logic         mispred;
    logic         hit_on_ubtb;
    logic         hit_on_ftb;
  } BPupdateInfo_t;

endpackage

module bpu_update_ctrl
  import bpu_update_pkg::*;
#(
  parameter int IDX_W  = 9,
  parameter int TAG_W  = 20,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_bpu_commit,
  input  BPupdateInfo_t      i_updateInfo,
  output logic               o_update_finished,
  output logic               o_tbl_rd_req,
  output logic [IDX_W-1:0]   o_tbl_rd_idx,
  output logic [TAG_W-1:0]   o_tbl_rd_tag,
  input  logic               i_tbl_rd_gnt,
  input  logic               i_tbl_rd_vld,
  input  logic               i_tbl_rd_hit,
  input  logic [1:0]         i_tbl_rd_ctr,
  output logic               o_tbl_wr_req,
  output logic [IDX_W-1:0]   o_tbl_wr_idx,
  output logic [TAG_W-1:0]   o_tbl_wr_tag,
  output logic [1:0]         o_tbl_wr_ctr,
  output logic [63:0]        o_tbl_wr_target,
  output logic [63:0]        o_tbl_wr_fallthru,
  output branch_type_t       o_tbl_wr_btype,
  input  logic               i_tbl_wr_gnt,
  output logic [31:0]        o_upd_cnt,
  output logic [31:0]        o_alloc_cnt,
  output logic [31:0]        o_skip_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [2:0] LAT_INIT  = 3'(RD_LAT);

  logic [2:0]         state;
  logic [2:0]         lat_cnt;

  // Latched request; only the fields the update actually needs are kept.
  logic [IDX_W-1:0]   idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic [63:0]        target_q;
  logic [63:0]        fallthru_q;
  branch_type_t       btype_q;
  logic               taken_q;
  logic               mispred_q;

  // Read response, held for one decision cycle after it arrives.
  logic               rsp_valid;
  logic               rsp_hit;
  logic [1:0]         rsp_ctr;

  logic [1:0]         new_ctr;
  logic               alloc_q;

  logic [1:0]         dec_ctr;
  logic               dec_write;
  logic               dec_alloc;

  // Address bits outside the index/tag window and the predictor-source hints
  // play no part in the update.
  logic               unused_info;
  assign unused_info = ^{i_updateInfo.startAddr[63:IDX_W+TAG_W+1],
                         i_updateInfo.startAddr[0],
                         i_updateInfo.hit_on_ubtb,
                         i_updateInfo.hit_on_ftb};

  // Write decision from the captured read result: saturating counter training
  // on a hit, weakly-taken allocation on a taken miss.
  always_comb begin
    dec_ctr   = rsp_ctr;
    dec_write = 1'b0;
    dec_alloc = 1'b0;
    if (rsp_hit) begin
      if (taken_q) begin
        dec_ctr = (rsp_ctr == 2'b11) ? 2'b11 : rsp_ctr + 2'd1;
      end else begin
        dec_ctr = (rsp_ctr == 2'b00) ? 2'b00 : rsp_ctr - 2'd1;
      end
      dec_write = (dec_ctr != rsp_ctr) || mispred_q;
    end else if (taken_q) begin
      dec_ctr   = 2'b10;
      dec_write = 1'b1;
      dec_alloc = 1'b1;
    end
  end

  // Update sequencer: latch, read, decide, optionally write, then complete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      lat_cnt     <= 3'd0;
      idx_q       <= '0;
      tag_q       <= '0;
      target_q    <= 64'd0;
      fallthru_q  <= 64'd0;
      btype_q     <= '0;
      taken_q     <= 1'b0;
      mispred_q   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_hit     <= 1'b0;
      rsp_ctr     <= 2'd0;
      new_ctr     <= 2'd0;
      alloc_q     <= 1'b0;
      o_upd_cnt   <= 32'd0;
      o_alloc_cnt <= 32'd0;
      o_skip_cnt  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_bpu_commit) begin
            idx_q      <= i_updateInfo.startAddr[IDX_W:1];
            tag_q      <= i_updateInfo.startAddr[IDX_W+TAG_W:IDX_W+1];
            target_q   <= i_updateInfo.targetAddr;
            fallthru_q <= i_updateInfo.fallthruAddr;
            btype_q    <= i_updateInfo.branch_type;
            taken_q    <= i_updateInfo.taken;
            mispred_q  <= i_updateInfo.mispred;
            state      <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (i_tbl_rd_gnt) begin
            lat_cnt   <= LAT_INIT;
            rsp_valid <= 1'b0;
            state     <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (!rsp_valid) begin
            if (lat_cnt != 3'd0) begin
              lat_cnt <= lat_cnt - 3'd1;
            end
            if (i_tbl_rd_vld) begin
              rsp_valid <= 1'b1;
              rsp_hit   <= i_tbl_rd_hit;
              rsp_ctr   <= i_tbl_rd_ctr;
            end
          end else begin
            new_ctr <= dec_ctr;
            alloc_q <= dec_alloc;
            if (dec_write) begin
              state <= S_WR_REQ;
            end else begin
              o_skip_cnt <= o_skip_cnt + 32'd1;
              state      <= S_DONE;
            end
          end
        end
        S_WR_REQ: begin
          if (i_tbl_wr_gnt) begin
            if (alloc_q) begin
              o_alloc_cnt <= o_alloc_cnt + 32'd1;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          o_upd_cnt <= o_upd_cnt + 32'd1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Port requests and completion are pure state decodes, so reset withdraws
  // them immediately and the commit input never reaches an output.
  assign o_tbl_rd_req      = (state == S_RD_REQ);
  assign o_tbl_wr_req      = (state == S_WR_REQ);
  assign o_update_finished = (state == S_DONE);

  assign o_tbl_rd_idx      = idx_q;
  assign o_tbl_rd_tag      = tag_q;
  assign o_tbl_wr_idx      = idx_q;
  assign o_tbl_wr_tag      = tag_q;
  assign o_tbl_wr_ctr      = new_ctr;
  assign o_tbl_wr_target   = target_q;
  assign o_tbl_wr_fallthru = fallthru_q;
  assign o_tbl_wr_btype    = btype_q;

  // The table returns read data a fixed RD_LAT cycles after the grant.
  rd_latency_check: assert property (
    @(posedge clk) disable iff (!rst)
    (state == S_RD_WAIT && !rsp_valid) |-> (i_tbl_rd_vld == (lat_cnt == 3'd1))
  ) else $error("read data latency differs from RD_LAT");

endmodule

`default_nettype wire

// File: tb/tb_bpu_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpu_update_ctrl
// Brief    : Directed bench for bpu_update_ctrl with a cycle-level table
//            responder and hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpu_update_ctrl;
  import bpu_update_pkg::*;

  localparam int IDX_W  = 9;
  localparam int TAG_W  = 20;
  localparam int RD_LAT = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               bpu_commit;
  BPupdateInfo_t      update_info;
  logic               update_finished;
  logic               tbl_rd_req;
  logic [IDX_W-1:0]   tbl_rd_idx;
  logic [TAG_W-1:0]   tbl_rd_tag;
  logic               tbl_rd_gnt;
  logic               tbl_rd_vld;
  logic               tbl_rd_hit;
  logic [1:0]         tbl_rd_ctr;
  logic               tbl_wr_req;
  logic [IDX_W-1:0]   tbl_wr_idx;
  logic [TAG_W-1:0]   tbl_wr_tag;
  logic [1:0]         tbl_wr_ctr;
  logic [63:0]        tbl_wr_target;
  logic [63:0]        tbl_wr_fallthru;
  branch_type_t       tbl_wr_btype;
  logic               tbl_wr_gnt;
  logic [31:0]        upd_cnt;
  logic [31:0]        alloc_cnt;
  logic [31:0]        skip_cnt;

  bpu_update_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .RD_LAT(RD_LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_bpu_commit      (bpu_commit),
    .i_updateInfo      (update_info),
    .o_update_finished (update_finished),
    .o_tbl_rd_req      (tbl_rd_req),
    .o_tbl_rd_idx      (tbl_rd_idx),
    .o_tbl_rd_tag      (tbl_rd_tag),
    .i_tbl_rd_gnt      (tbl_rd_gnt),
    .i_tbl_rd_vld      (tbl_rd_vld),
    .i_tbl_rd_hit      (tbl_rd_hit),
    .i_tbl_rd_ctr      (tbl_rd_ctr),
    .o_tbl_wr_req      (tbl_wr_req),
    .o_tbl_wr_idx      (tbl_wr_idx),
    .o_tbl_wr_tag      (tbl_wr_tag),
    .o_tbl_wr_ctr      (tbl_wr_ctr),
    .o_tbl_wr_target   (tbl_wr_target),
    .o_tbl_wr_fallthru (tbl_wr_fallthru),
    .o_tbl_wr_btype    (tbl_wr_btype),
    .i_tbl_wr_gnt      (tbl_wr_gnt),
    .o_upd_cnt         (upd_cnt),
    .o_alloc_cnt       (alloc_cnt),
    .o_skip_cnt        (skip_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Observations collected by txn for one update sequence.
  int                 fin_frame;
  int                 fin_pulses;
  int                 rd_frames;
  int                 wr_frames;
  int                 first_rd;
  logic               both_hi;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [TAG_W-1:0]   rd_tag_s;
  logic [IDX_W-1:0]   wr_idx_s;
  logic [TAG_W-1:0]   wr_tag_s;
  logic [1:0]         wr_ctr_s;
  logic [63:0]        wr_tgt_s;
  logic [63:0]        wr_ft_s;
  logic [2:0]         wr_bt_s;

  BPupdateInfo_t      info;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic BPupdateInfo_t mk(input logic [63:0] sa, input logic [63:0] ft,
                                       input logic [63:0] tg, input logic [2:0] bt,
                                       input logic tk, input logic mp);
    BPupdateInfo_t r;
    r = '0;
    r.startAddr    = sa;
    r.fallthruAddr = ft;
    r.targetAddr   = tg;
    r.branch_type  = bt;
    r.taken        = tk;
    r.mispred      = mp;
    return r;
  endfunction

  // Called just after a falling edge with the DUT idle. Frame f is the
  // interval after the f-th following falling edge; the commit is sampled on
  // the rising edge between frame 0 and frame 1. The loop plays the table:
  // grants after the requested number of waiting frames, read data RD_LAT
  // frames after the read grant.
  task automatic txn(input BPupdateInfo_t ti, input int rd_wait, input logic hit,
                     input logic [1:0] ctr, input int wr_wait, input logic hold);
    int gnt_frame;
    fin_frame  = -1;
    fin_pulses = 0;
    rd_frames  = 0;
    wr_frames  = 0;
    first_rd   = -1;
    both_hi    = 1'b0;
    gnt_frame  = -100;
    bpu_commit  = 1'b1;
    update_info = ti;
    for (int f = 1; f <= 60 && !(fin_frame >= 0 && f > fin_frame + 2); f++) begin
      @(negedge clk);
      if (!hold && f == 1) begin
        bpu_commit  = 1'b0;
        update_info = '1;
      end
      tbl_rd_gnt = 1'b0;
      tbl_wr_gnt = 1'b0;
      tbl_rd_vld = 1'b0;
      tbl_rd_hit = 1'b0;
      tbl_rd_ctr = 2'd0;
      if (tbl_rd_req && tbl_wr_req) both_hi = 1'b1;
      if (tbl_rd_req) begin
        if (first_rd < 0) first_rd = f;
        rd_frames++;
        rd_idx_s = tbl_rd_idx;
        rd_tag_s = tbl_rd_tag;
        if (rd_frames > rd_wait) begin
          tbl_rd_gnt = 1'b1;
          gnt_frame  = f;
        end
      end
      if (f == gnt_frame + RD_LAT) begin
        tbl_rd_vld = 1'b1;
        tbl_rd_hit = hit;
        tbl_rd_ctr = ctr;
      end
      if (tbl_wr_req) begin
        wr_frames++;
        wr_idx_s = tbl_wr_idx;
        wr_tag_s = tbl_wr_tag;
        wr_ctr_s = tbl_wr_ctr;
        wr_tgt_s = tbl_wr_target;
        wr_ft_s  = tbl_wr_fallthru;
        wr_bt_s  = tbl_wr_btype;
        if (wr_frames > wr_wait) tbl_wr_gnt = 1'b1;
      end
      if (update_finished) begin
        fin_pulses++;
        if (fin_frame < 0) fin_frame = f;
        bpu_commit = 1'b0;
      end
    end
    bpu_commit  = 1'b0;
    update_info = '0;
    tbl_rd_gnt  = 1'b0;
    tbl_wr_gnt  = 1'b0;
    tbl_rd_vld  = 1'b0;
    tbl_rd_hit  = 1'b0;
    tbl_rd_ctr  = 2'd0;
  endtask

  initial begin
    rst         = 1'b0;
    bpu_commit  = 1'b0;
    update_info = '0;
    tbl_rd_gnt  = 1'b0;
    tbl_rd_vld  = 1'b0;
    tbl_rd_hit  = 1'b0;
    tbl_rd_ctr  = 2'd0;
    tbl_wr_gnt  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_rd_req",   64'(tbl_rd_req),      64'd0);
    check("rst_wr_req",   64'(tbl_wr_req),      64'd0);
    check("rst_finished", 64'(update_finished), 64'd0);
    check("rst_upd_cnt",  64'(upd_cnt),         64'd0);
    check("rst_alloc",    64'(alloc_cnt),       64'd0);
    check("rst_skip",     64'(skip_cnt),        64'd0);
    check("rst_rd_idx",   64'(tbl_rd_idx),      64'd0);
    check("rst_wr_tgt",   tbl_wr_target,        64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: hit, taken, ctr 1 -> write ctr 2, finished 5 cycles after commit
    info = mk(64'h8000_1000, 64'h8000_1010, 64'h8000_0400, 3'd1, 1'b1, 1'b0);
    txn(info, 0, 1'b1, 2'd1, 0, 1'b1);
    check("t1_rd_idx",   64'(rd_idx_s),   64'h000);
    check("t1_rd_tag",   64'(rd_tag_s),   64'h00004);
    check("t1_wr_ctr",   64'(wr_ctr_s),   64'd2);
    check("t1_wr_tgt",   wr_tgt_s,        64'h8000_0400);
    check("t1_wr_ft",    wr_ft_s,         64'h8000_1010);
    check("t1_wr_bt",    64'(wr_bt_s),    64'd1);
    check("t1_fin_frm",  64'(fin_frame),  64'd5);
    check("t1_pulses",   64'(fin_pulses), 64'd1);
    check("t1_upd_cnt",  64'(upd_cnt),    64'd1);

    // 2: hit, taken, ctr 3, no mispred -> skip
    info = mk(64'h8000_1000, 64'h8000_1010, 64'h8000_0400, 3'd1, 1'b1, 1'b0);
    txn(info, 0, 1'b1, 2'd3, 0, 1'b1);
    check("t2_wr_frames", 64'(wr_frames), 64'd0);
    check("t2_fin_frm",   64'(fin_frame), 64'd4);
    check("t2_skip",      64'(skip_cnt),  64'd1);
    check("t2_upd_cnt",   64'(upd_cnt),   64'd2);

    // 2b: hit, taken, ctr 3, mispredicted -> write even though ctr unchanged
    info = mk(64'h8000_1000, 64'h8000_1010, 64'h8000_0400, 3'd1, 1'b1, 1'b1);
    txn(info, 0, 1'b1, 2'd3, 0, 1'b1);
    check("t2b_wr_frames", 64'(wr_frames), 64'd1);
    check("t2b_wr_ctr",    64'(wr_ctr_s),  64'd3);
    check("t2b_skip",      64'(skip_cnt),  64'd1);
    check("t2b_alloc",     64'(alloc_cnt), 64'd0);

    // 3: miss, taken -> allocate; commit dropped after one cycle
    info = mk(64'h0123_4566, 64'h0123_4570, 64'h8000_2000, 3'd2, 1'b1, 1'b0);
    txn(info, 0, 1'b0, 2'd0, 0, 1'b0);
    check("t3_rd_idx",  64'(rd_idx_s),  64'h0B3);
    check("t3_rd_tag",  64'(rd_tag_s),  64'h048D1);
    check("t3_wr_idx",  64'(wr_idx_s),  64'h0B3);
    check("t3_wr_tag",  64'(wr_tag_s),  64'h048D1);
    check("t3_wr_ctr",  64'(wr_ctr_s),  64'd2);
    check("t3_wr_tgt",  wr_tgt_s,       64'h8000_2000);
    check("t3_wr_bt",   64'(wr_bt_s),   64'd2);
    check("t3_fin_frm", 64'(fin_frame), 64'd5);
    check("t3_alloc",   64'(alloc_cnt), 64'd1);
    check("t3_upd_cnt", 64'(upd_cnt),   64'd4);

    // 4: miss, not taken -> skip, single pulse
    info = mk(64'h0000_0040, 64'h0000_0048, 64'h0000_0100, 3'd1, 1'b0, 1'b0);
    txn(info, 0, 1'b0, 2'd2, 0, 1'b1);
    check("t4_wr_frames", 64'(wr_frames),  64'd0);
    check("t4_pulses",    64'(fin_pulses), 64'd1);
    check("t4_skip",      64'(skip_cnt),   64'd2);
    check("t4_alloc",     64'(alloc_cnt),  64'd1);

    // 5: hit, not taken, ctr 2 -> ctr 1; read port busy 7, write port busy 3
    info = mk(64'h8000_0010, 64'h8000_0020, 64'h8000_0800, 3'd3, 1'b0, 1'b0);
    txn(info, 7, 1'b1, 2'd2, 3, 1'b1);
    check("t5_rd_frames", 64'(rd_frames),  64'd8);
    check("t5_wr_frames", 64'(wr_frames),  64'd4);
    check("t5_both_hi",   64'(both_hi),    64'd0);
    check("t5_pulses",    64'(fin_pulses), 64'd1);
    check("t5_wr_ctr",    64'(wr_ctr_s),   64'd1);
    check("t5_fin_frm",   64'(fin_frame),  64'd15);
    check("t5_upd_cnt",   64'(upd_cnt),    64'd6);

    // 6: reset during RD_WAIT, mid-cycle
    bpu_commit  = 1'b1;
    update_info = mk(64'h8000_1234, 64'h8000_1240, 64'h8000_3000, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_rd_req", 64'(tbl_rd_req), 64'd1);
    tbl_rd_gnt = 1'b1;
    @(negedge clk);
    tbl_rd_gnt = 1'b0;
    bpu_commit = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t6_rst_rd_req",   64'(tbl_rd_req),      64'd0);
    check("t6_rst_wr_req",   64'(tbl_wr_req),      64'd0);
    check("t6_rst_finished", 64'(update_finished), 64'd0);
    check("t6_rst_upd",      64'(upd_cnt),         64'd0);
    check("t6_rst_alloc",    64'(alloc_cnt),       64'd0);
    check("t6_rst_skip",     64'(skip_cnt),        64'd0);
    check("t6_rst_rd_tag",   64'(tbl_rd_tag),      64'd0);
    @(negedge clk);
    check("t6_rst_hold_fin", 64'(update_finished), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    info = mk(64'h8000_1000, 64'h8000_1010, 64'h8000_0400, 3'd1, 1'b1, 1'b0);
    txn(info, 0, 1'b1, 2'd1, 0, 1'b1);
    check("t6_first_rd", 64'(first_rd),   64'd1);
    check("t6_wr_ctr",   64'(wr_ctr_s),   64'd2);
    check("t6_pulses",   64'(fin_pulses), 64'd1);
    check("t6_upd_cnt",  64'(upd_cnt),    64'd1);
    check("t6_skip",     64'(skip_cnt),   64'd0);
    check("t6_alloc",    64'(alloc_cnt),  64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
